// File: rtl/parking_pkg.sv
// parking_pkg: shared widths and helpers for the parking occupancy counter
package parking_pkg;
  localparam int MAX_LANES = 8;
  localparam int FILT_W = 4;

  function automatic int clog2(input int v);
    int n;
    n = 0;
    while ((1 << n) < v) n++;
    return n;
  endfunction

  localparam int PC_W = clog2(MAX_LANES + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_LANES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/sensor_filter.sv
// sensor_filter: debounces one sensor and emits a one-cycle pulse per armed rising level
module sensor_filter
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic evt
);
  localparam logic [FILT_W-1:0] DB = FILT_W'(DEBOUNCE);
  logic [FILT_W-1:0] cnt_q, cnt_d;
  logic armed_q, armed_d, lvl_q, lvl_d, evt_q, evt_d;
  // Counter saturates at DEBOUNCE; a lane arms only after a low sample so a level held through reset never counts
  always_comb begin
    cnt_d = din ? ((cnt_q >= DB) ? cnt_q : cnt_q + FILT_W'(1)) : '0;
    lvl_d = din && (cnt_d >= DB);
    armed_d = armed_q || !din;
    evt_d = lvl_d && !lvl_q && armed_q;
  end
  // Filter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      armed_q <= 1'b0;
      lvl_q <= 1'b0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      lvl_q <= lvl_d;
      evt_q <= evt_d;
    end
  end
  assign evt = evt_q;
endmodule

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: multi-lane saturating occupancy counter with reject pulses
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = 7,
  parameter int NUM_LANES = 1,
  parameter int DEBOUNCE = 2,
  parameter int CNT_W = clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] s,
  input  logic [NUM_LANES-1:0] r,
  output logic [CNT_W-1:0]     leds,
  output logic [CNT_W-1:0]     free,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_LANES-1:0] entry_reject,
  output logic [NUM_LANES-1:0] exit_reject
);
  localparam int AW = (CNT_W + 1 > PC_W) ? CNT_W + 1 : PC_W;
  localparam logic [AW-1:0] CAP = AW'(CAPACITY);
  logic [NUM_LANES-1:0] en_evt, ex_evt, en_rej_d, ex_rej_d, en_rej_q, ex_rej_q;
  logic [CNT_W-1:0] leds_q, leds_d, free_q, free_d;
  logic full_q, full_d, empty_q, empty_d;
  logic [AW-1:0] cur, x, xa, e, ea, room, ex_k, en_k, nxt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_s (.clk(clk), .rst(rst), .din(s[i]), .evt(en_evt[i]));
    sensor_filter #(.DEBOUNCE(DEBOUNCE)) u_r (.clk(clk), .rst(rst), .din(r[i]), .evt(ex_evt[i]));
  end

  // Exits resolve first against current occupancy, then entries against the space left; lowest lanes win
  always_comb begin
    cur = AW'(leds_q);
    x = AW'(popcount(MAX_LANES'(ex_evt)));
    e = AW'(popcount(MAX_LANES'(en_evt)));
    xa = (x > cur) ? cur : x;
    room = CAP - (cur - xa);
    ea = (e > room) ? room : e;
    nxt = cur - xa + ea;
    ex_k = '0;
    en_k = '0;
    ex_rej_d = '0;
    en_rej_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ex_rej_d[i] = ex_evt[i] && (ex_k >= xa);
      ex_k = ex_k + AW'(ex_evt[i]);
      en_rej_d[i] = en_evt[i] && (en_k >= ea);
      en_k = en_k + AW'(en_evt[i]);
    end
    leds_d = CNT_W'(nxt);
    free_d = CNT_W'(CAP - nxt);
    full_d = nxt == CAP;
    empty_d = nxt == '0;
  end

  // Count, flags and reject pulses update together so they always agree
  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q <= '0;
      free_q <= CNT_W'(CAPACITY);
      full_q <= 1'b0;
      empty_q <= 1'b1;
      en_rej_q <= '0;
      ex_rej_q <= '0;
    end else begin
      leds_q <= leds_d;
      free_q <= free_d;
      full_q <= full_d;
      empty_q <= empty_d;
      en_rej_q <= en_rej_d;
      ex_rej_q <= ex_rej_d;
    end
  end

  assign leds = leds_q;
  assign free = free_q;
  assign full = full_q;
  assign empty = empty_q;
  assign entry_reject = en_rej_q;
  assign exit_reject = ex_rej_q;
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// tb_parking_occupancy_counter: directed checks on a default lot and a 2-lane, 3-space lot
module tb_parking_occupancy_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s1 = 1'b0, r1 = 1'b0;
  logic [1:0] s2 = 2'b00, r2 = 2'b00;
  logic [2:0] leds1, free1;
  logic full1, empty1, er1, xr1;
  logic [1:0] leds2, free2, er2, xr2;
  logic full2, empty2;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  parking_occupancy_counter u1 (
    .clk(clk), .rst(rst), .s(s1), .r(r1), .leds(leds1), .free(free1),
    .full(full1), .empty(empty1), .entry_reject(er1), .exit_reject(xr1)
  );

  parking_occupancy_counter #(.CAPACITY(3), .NUM_LANES(2)) u2 (
    .clk(clk), .rst(rst), .s(s2), .r(r2), .leds(leds2), .free(free2),
    .full(full2), .empty(empty2), .entry_reject(er2), .exit_reject(xr2)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_s1();
    s1 = 1'b1;
    tick(5);
    s1 = 1'b0;
    tick(5);
  endtask

  task automatic pulse_r1();
    r1 = 1'b1;
    tick(5);
    r1 = 1'b0;
    tick(5);
  endtask

  task automatic pulse2(input logic [1:0] sv, input logic [1:0] rv);
    s2 = sv;
    r2 = rv;
    tick(5);
    s2 = 2'b00;
    r2 = 2'b00;
    tick(5);
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick(2);
    chk("rst_leds", leds1, 0);
    chk("rst_free", free1, 7);
    chk("rst_full", full1, 0);
    chk("rst_empty", empty1, 1);
    chk("rst_rej", {er1, xr1}, 0);
    chk("rst_free2", free2, 3);

    s1 = 1'b1;
    tick(2);
    chk("lat_before", leds1, 0);
    tick(1);
    chk("lat_after", leds1, 1);
    tick(2);
    s1 = 1'b0;
    tick(5);
    for (int i = 2; i <= 7; i++) begin
      pulse_s1();
      chk("fill_leds", leds1, i);
    end
    chk("full_flag", full1, 1);
    chk("full_free", free1, 0);
    chk("full_empty", empty1, 0);

    s1 = 1'b1;
    tick(2);
    chk("ovf_rej_early", er1, 0);
    tick(1);
    chk("ovf_rej", er1, 1);
    chk("ovf_leds", leds1, 7);
    tick(1);
    chk("ovf_rej_clear", er1, 0);
    s1 = 1'b0;
    tick(6);

    for (int i = 1; i <= 7; i++) begin
      pulse_r1();
      chk("drain_leds", leds1, 7 - i);
    end
    r1 = 1'b1;
    tick(3);
    chk("udf_rej", xr1, 1);
    chk("udf_leds", leds1, 0);
    chk("udf_empty", empty1, 1);
    chk("udf_free", free1, 7);
    tick(1);
    chk("udf_rej_clear", xr1, 0);
    r1 = 1'b0;
    tick(6);

    s1 = 1'b1;
    tick(1);
    s1 = 1'b0;
    tick(5);
    chk("glitch", leds1, 0);
    s1 = 1'b1;
    tick(40);
    chk("hold_once", leds1, 1);
    s1 = 1'b0;
    tick(5);
    chk("hold_release", leds1, 1);

    for (int i = 0; i < 3; i++) pulse_s1();
    chk("pre_rst", leds1, 4);
    s1 = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_leds", leds1, 0);
    chk("mid_rst_empty", empty1, 1);
    tick(10);
    chk("held_no_count", leds1, 0);
    s1 = 1'b0;
    tick(2);
    pulse_s1();
    chk("rearm_count", leds1, 1);

    pulse2(2'b01, 2'b00);
    pulse2(2'b01, 2'b00);
    chk("l2_pre", leds2, 2);
    s2 = 2'b11;
    tick(3);
    chk("l2_dual_leds", leds2, 3);
    chk("l2_dual_rej", er2, 2'b10);
    chk("l2_dual_full", full2, 1);
    tick(1);
    chk("l2_dual_rej_clear", er2, 0);
    s2 = 2'b00;
    tick(6);
    s2 = 2'b11;
    r2 = 2'b01;
    tick(3);
    chk("l2_mix_leds", leds2, 3);
    chk("l2_mix_erej", er2, 2'b10);
    chk("l2_mix_xrej", xr2, 0);
    tick(2);
    s2 = 2'b00;
    r2 = 2'b00;
    tick(5);

    pulse2(2'b00, 2'b01);
    pulse2(2'b00, 2'b01);
    chk("l2_one", leds2, 1);
    r2 = 2'b11;
    tick(3);
    chk("l2_exit_leds", leds2, 0);
    chk("l2_exit_rej", xr2, 2'b10);
    chk("l2_exit_empty", empty2, 1);
    chk("l2_exit_free", free2, 3);
    r2 = 2'b00;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
